// File: rtl/grn_rd_engine.sv
// GRN AFU host read engine: issues CCI-P c0 line reads, reorders responses by tag.
// Build option GRN_RD_TAG_CHECK_EN enables the sticky tag-error check on err.
module grn_rd_engine #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [41:0]  src_addr,
    input  logic [31:0]  num_lines,
    input  logic         c0TxAlmFull,
    output logic         c0_tx_valid,
    output logic [41:0]  c0_tx_addr,
    output logic [15:0]  c0_tx_mdata,
    input  logic         c0_rx_valid,
    input  logic [15:0]  c0_rx_mdata,
    input  logic [511:0] c0_rx_data,
    output logic         out_valid,
    output logic [511:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int TAG_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [41:0]        r_src_addr;
    logic [31:0]        r_num_lines;
    logic [31:0]        r_req_cnt;
    logic [31:0]        r_dlv_cnt;
    logic [DEPTH-1:0]   r_slot_vld;
    logic [511:0]       r_ram [DEPTH];
    logic               r_busy;
    logic               r_done;

    logic [TAG_W-1:0]   w_head;
    logic [TAG_W-1:0]   w_tag;
    logic [31:0]        w_occ;
    logic [31:0]        w_req_nxt;
    logic [31:0]        w_dlv_nxt;
    logic               w_issue;
    logic               w_hs;
    logic               w_wr;
    logic               w_unused;

    assign w_head    = r_dlv_cnt[TAG_W-1:0];
    assign w_tag     = c0_rx_mdata[TAG_W-1:0];
    assign w_occ     = r_req_cnt - r_dlv_cnt;
    assign w_req_nxt = r_req_cnt + 32'd1;
    assign w_dlv_nxt = r_dlv_cnt + 32'd1;
    assign w_unused  = &{1'b0, c0_rx_mdata[15:TAG_W]};

    assign w_issue = (r_state == S_RUN) && (r_req_cnt < r_num_lines)
                   && !c0TxAlmFull && (w_occ < 32'(DEPTH));

    assign out_valid = r_slot_vld[w_head];
    assign out_data  = r_ram[w_head];
    assign out_last  = out_valid && (r_dlv_cnt == r_num_lines - 32'd1);
    assign w_hs      = out_valid && out_ready;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef GRN_RD_TAG_CHECK_EN
    logic r_err;

    // Accept only while a job is live and the slot is free; anything else is a tag error.
    assign w_wr = c0_rx_valid && !r_slot_vld[w_tag]
               && ((r_state == S_RUN) || (r_state == S_DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (c0_rx_valid && !w_wr) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wr = c0_rx_valid;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_src_addr  <= '0;
            r_num_lines <= '0;
            r_req_cnt   <= '0;
            r_dlv_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            c0_tx_valid <= 1'b0;
            c0_tx_addr  <= '0;
            c0_tx_mdata <= '0;
        end else begin
            c0_tx_valid <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_req_cnt <= '0;
                    r_dlv_cnt <= '0;
                    if (start) begin
                        if (num_lines == 32'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_busy      <= 1'b1;
                            r_src_addr  <= src_addr;
                            r_num_lines <= num_lines;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        c0_tx_valid <= 1'b1;
                        c0_tx_addr  <= r_src_addr + {10'd0, r_req_cnt};
                        c0_tx_mdata <= {{(16-TAG_W){1'b0}}, r_req_cnt[TAG_W-1:0]};
                        r_req_cnt   <= w_req_nxt;
                        if (w_req_nxt == r_num_lines) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    if (w_hs) begin
                        r_dlv_cnt <= w_dlv_nxt;
                    end
                end
                S_DRAIN: begin
                    if (w_hs) begin
                        r_dlv_cnt <= w_dlv_nxt;
                    end
                    // Look at the post-handshake count so done follows the last beat directly.
                    if ((w_hs ? w_dlv_nxt : r_dlv_cnt) == r_num_lines) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= '0;
        end else if (r_state == S_IDLE) begin
            r_slot_vld <= '0;
        end else begin
            if (w_hs) begin
                r_slot_vld[w_head] <= 1'b0;
            end
            if (w_wr) begin
                r_slot_vld[w_tag] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_ram[w_tag] <= c0_rx_data;
        end
    end

endmodule
